// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU stores enqueue bytes into a TX FIFO that
// an 8N1 serializer drains; a registered status word reports FIFO/serializer state.
module uart_tx_mmio #(
    parameter logic [31:0] TX_ADDR      = 32'hFFFF_FFF0,
    parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FFF4,
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_wen,
    input  logic [31:0] mem_wa,
    input  logic [31:0] mem_wd,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_ra,
    output logic [31:0] status_rd,
    output logic        tx
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state;
    logic [BAUD_W-1:0]   baud;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;

    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                overflow;

    logic push_c;
    logic clr_c;
    logic full_c;
    logic empty_c;
    logic wr_en_c;
    logic pop_c;
    logic busy_c;
    logic unused_c;

    // Store decode; the store width is irrelevant, only the low byte is queued.
    assign push_c   = mem_wen && (mem_wa == TX_ADDR);
    assign clr_c    = mem_wen && (mem_wa == STATUS_ADDR);
    assign full_c   = (count == CNT_FULL);
    assign empty_c  = (count == '0);
    assign wr_en_c  = push_c && !full_c;
    assign busy_c   = (state != IDLE);
    assign unused_c = ^{mem_funct3, mem_wd[31:8]};

    // Pop whenever the serializer is ready for a new byte: idle, or at stop-bit expiry.
    assign pop_c = !empty_c && ((state == IDLE) || ((state == STOP) && (baud == '0)));

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            fifo_mem[wr_ptr] <= mem_wd[7:0];
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_c && full_c) begin
                overflow <= 1'b1;
            end else if (clr_c) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serializer: tx is registered and updated on the same edge as each state/bit change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop_c) begin
                        shift <= fifo_mem[rd_ptr];
                        baud  <= BAUD_RELOAD;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud == '0) begin
                        baud    <= BAUD_RELOAD;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud - BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud == '0) begin
                        baud <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud - BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud == '0) begin
                        if (pop_c) begin
                            shift <= fifo_mem[rd_ptr];
                            baud  <= BAUD_RELOAD;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud - BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_rd <= '0;
        end else if (mem_ra == STATUS_ADDR) begin
            status_rd <= {23'd0, 5'(count), overflow, busy_c, empty_c, full_c};
        end else begin
            status_rd <= '0;
        end
    end

endmodule
